// File: rtl/lcd_timing_pkg.sv
// Shared LCD timing definitions: preset selector encoding, preset interval table,
// ns-to-cycle conversion (rounded up) and the timer state encoding.
package lcd_timing_pkg;

    typedef enum logic [2:0] {
        SEL_250NS  = 3'd0,
        SEL_42US   = 3'd1,
        SEL_100US  = 3'd2,
        SEL_1640US = 3'd3,
        SEL_4100US = 3'd4,
        SEL_15MS   = 3'd5,
        SEL_50MS   = 3'd6,
        SEL_RAW    = 3'd7
    } preset_e;

    localparam int NUM_PRESETS = 7;

    // Interval lengths in ns, indexed by preset_e (SEL_RAW excluded).
    localparam longint unsigned PRESET_NS [NUM_PRESETS] = '{
        64'd250,
        64'd42_000,
        64'd100_000,
        64'd1_640_000,
        64'd4_100_000,
        64'd15_000_000,
        64'd50_000_000
    };

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    function automatic longint unsigned cycles_from_ns(
        input longint unsigned clk_hz,
        input longint unsigned ns
    );
        return (clk_hz * ns + 64'd999_999_999) / 64'd1_000_000_000;
    endfunction

endpackage

// File: rtl/lcd_delay_target_mux.sv
// Selects the run length T from a CLK_HZ-derived preset or the raw wait_time,
// forcing a zero-length request up to a single cycle.
module lcd_delay_target_mux
    import lcd_timing_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          CNT_W  = 23,
    parameter int          SEL_W  = 3
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [CNT_W-1:0] wait_time,
    output logic [CNT_W-1:0] target
);

    logic [CNT_W-1:0] preset_tbl [NUM_PRESETS];
    logic [CNT_W-1:0] raw_target;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PRESETS; gi++) begin : g_preset
            localparam longint unsigned CYC = cycles_from_ns(64'(CLK_HZ), PRESET_NS[gi]);
            if (CYC >= (64'd1 << CNT_W)) begin : g_too_narrow
                $error("lcd_delay_target_mux: CNT_W too small for preset %0d (%0d cycles)", gi, CYC);
            end
            assign preset_tbl[gi] = CNT_W'(CYC);
        end
    endgenerate

    always_comb begin
        raw_target = wait_time;
        if (sel < SEL_W'(NUM_PRESETS)) begin
            raw_target = preset_tbl[sel];
        end
        target = (raw_target == '0) ? CNT_W'(1) : raw_target;
    end

endmodule

// File: rtl/lcd_delay_timer.sv
// One-shot programmable delay timer for LCD sequencing with start/busy/done handshake.
// Optional abort input is compiled in when LCD_DELAY_ABORT_EN is defined.
module lcd_delay_timer
    import lcd_timing_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          CNT_W  = 23,
    parameter int          SEL_W  = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [SEL_W-1:0] sel,
    input  logic [CNT_W-1:0] wait_time,
`ifdef LCD_DELAY_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             flag_xs,
    output logic [CNT_W-1:0] remaining
);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             flag_reg, flag_next;
    logic [CNT_W-1:0] target;
    logic             abort_req;

`ifdef LCD_DELAY_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    lcd_delay_target_mux #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W),
        .SEL_W  (SEL_W)
    ) u_target_mux (
        .sel       (sel),
        .wait_time (wait_time),
        .target    (target)
    );

    // remaining shows T in the first counting cycle, so the run expires on
    // the edge after it shows 2; that puts done exactly T cycles after start.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        flag_next      = flag_reg;

        if (state_reg == COUNT && abort_req) begin
            state_next     = IDLE;
            remaining_next = '0;
            busy_next      = 1'b0;
        end else if (start) begin
            flag_next = 1'b0;
            if (target == CNT_W'(1)) begin
                state_next     = IDLE;
                remaining_next = '0;
                busy_next      = 1'b0;
                done_next      = 1'b1;
                flag_next      = 1'b1;
            end else begin
                state_next     = COUNT;
                remaining_next = target;
                busy_next      = 1'b1;
            end
        end else if (state_reg == COUNT) begin
            if (remaining_reg <= CNT_W'(2)) begin
                state_next     = IDLE;
                remaining_next = '0;
                busy_next      = 1'b0;
                done_next      = 1'b1;
                flag_next      = 1'b1;
            end else begin
                remaining_next = remaining_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            flag_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            flag_reg      <= flag_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign flag_xs   = flag_reg;
    assign remaining = remaining_reg;

endmodule
